mem_bus_initiator: RTL
======================

MEM_BUS_INITIATOR -- requirements
Module: mem_bus_initiator

Interface
REQ-001 SHALL have parameter SOURCE_ID, default 1: the bus source tag this initiator places on requests and matches on responses.
REQ-002 SHALL have parameter MEM_BYTES, default 65536: the DRAM storage size in bytes, used for the address range check.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: the response watchdog limit (see Configuration).
REQ-004 SHALL have ports, one per item:
- clk, input, 1: sole clock; all logic is on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- cpu_req_valid, input, 1: CPU request present.
- cpu_req_ready, output, 1: initiator can accept a CPU request.
- cpu_req_write, input, 1: 1 = write, 0 = read.
- cpu_req_address, input, 64: byte address.
- cpu_req_wdata, input, 64: write payload.
- cpu_rsp_valid, output, 1: one-cycle completion pulse.
- cpu_rsp_rdata, output, 64: read data.
- cpu_rsp_error, output, 1: completion is an error.
- bus_req_valid, output, 1: bus packet offered.
- bus_req_ready, input, 1: the responder is not busy.
- bus_req_type, output, bus_packet_type_t: bus_read_data or bus_write_data.
- bus_req_address, output, 64: packet address.
- bus_req_payload, output, bus_packet_payload_t (64): packet payload.
- bus_req_source, output, 8: SOURCE_ID.
- bus_rsp_valid, input, 1: read response present.
- bus_rsp_payload, input, 64: read data.
- bus_rsp_dest, input, 8: response destination tag.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT_RSP and DONE.
REQ-006 cpu_req_ready SHALL be 1 only in IDLE.
REQ-007 A CPU request is accepted on a cycle with cpu_req_valid && cpu_req_ready; its fields SHALL be latched on that cycle.
REQ-008 Range check on acceptance:
- Failure condition: cpu_req_address > MEM_BYTES-8 (the check is unsigned).
- On failure: go to DONE with error=1; no bus packet is issued.
- On pass: go to ISSUE.
REQ-009 In ISSUE, bus_req_valid SHALL be 1 with the latched fields held stable until a cycle where bus_req_ready=1.
REQ-010 ISSUE transitions on transfer (bus_req_ready=1):
- Write: go to DONE. Writes are posted; no bus acknowledge is expected.
- Read: go to WAIT_RSP.
REQ-011 In WAIT_RSP, a response with bus_rsp_valid=1 and bus_rsp_dest==SOURCE_ID SHALL:
- latch bus_rsp_payload into cpu_rsp_rdata;
- go to DONE with error=0.
REQ-012 Responses with non-matching dest, or arriving in any state other than WAIT_RSP, SHALL be ignored without side effect.
REQ-013 DONE SHALL drive cpu_rsp_valid=1 for exactly one cycle, then return to IDLE.
- Minimum latency, request acceptance to cpu_rsp_valid, for a write with bus_req_ready already high: 2 cycles.
REQ-014 cpu_rsp_rdata SHALL hold its last value until the next read completion; writes and errors leave it unchanged.
REQ-015 bus_req_valid SHALL be 0 in every state except ISSUE.

Reset
REQ-016 When rst_n=0, the block SHALL take these values immediately:
- FSM state: IDLE.
- cpu_req_ready=1 (follows IDLE).
- bus_req_valid=0.
- cpu_rsp_valid=0, cpu_rsp_error=0.
- cpu_rsp_rdata=0, bus_req_address=0, bus_req_payload=0.
- watchdog counter=0.
REQ-017 A reset during ISSUE or WAIT_RSP SHALL abandon the transaction; no cpu_rsp_valid is produced for it, and a later response for it is ignored per REQ-012.

Configuration
REQ-018 With macro MEM_BUS_TIMEOUT_EN defined, the watchdog SHALL behave as follows:
- A 16-bit counter clears on entry to WAIT_RSP and increments each cycle spent there.
- When the counter reaches TIMEOUT_CYCLES-1 without a matching response, go to DONE with error=1.
REQ-019 Without MEM_BUS_TIMEOUT_EN, no counter SHALL exist, and WAIT_RSP waits indefinitely.

Structure
REQ-020 bus_packet_type_t, bus_packet_payload_t and the FSM state enum SHALL live in the shared bus package, alongside the existing DRAM-side types.
REQ-021 The block SHALL be a single module with no sub-modules; the watchdog is inline, under the macro guard.

Verification
REQ-022 Read: addr 0x10, DRAM model returns 0x1122334455667788 with dest=1 → cpu_rsp_rdata=0x1122334455667788, error=0, exactly one cpu_rsp_valid pulse.
REQ-023 Write with back-pressure: addr 0x20, data 0xDEADBEEF, bus_req_ready held low 3 cycles → packet held stable for 4 cycles total, then cpu_rsp_valid, error=0.
REQ-024 Range fault: addr MEM_BYTES-7 → no bus_req_valid ever, cpu_rsp_valid with error=1 one cycle after acceptance.
REQ-025 Foreign response: dest=2 response injected during WAIT_RSP, then a dest=1 response with 0x5A → only the 0x5A data is returned.
REQ-026 Timeout (macro on, TIMEOUT_CYCLES=8): no response → error=1 after 8 WAIT_RSP cycles; a late response for that read is ignored.
REQ-027 Reset in WAIT_RSP: rst_n pulsed low → outputs at reset values immediately, next request completes normally.

Source files
------------

// File: rtl/mem_bus_initiator_pkg.sv
// Shared memory-bus package: DRAM-side types plus the bus packet and
// initiator FSM types used by mem_bus_initiator.
package mem_bus_initiator_pkg;

  typedef logic [63:0] dram_addr_t;
  typedef logic [63:0] dram_word_t;

  typedef enum logic {
    dram_cmd_read  = 1'b0,
    dram_cmd_write = 1'b1
  } dram_cmd_t;

  typedef enum logic [1:0] {
    bus_read_data  = 2'd0,
    bus_write_data = 2'd1
  } bus_packet_type_t;

  typedef logic [63:0] bus_packet_payload_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } initiator_state_t;

  // A 64-bit access must fit entirely inside the DRAM storage.
  function automatic logic addr_in_range(input dram_addr_t addr,
                                         input dram_addr_t mem_bytes);
    return addr <= (mem_bytes - 64'd8);
  endfunction

endpackage

// File: rtl/mem_bus_initiator.sv
// CPU-to-memory-bus initiator: one outstanding request, posted writes.
// Optional response watchdog enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_initiator
  import mem_bus_initiator_pkg::*;
#(
  parameter int SOURCE_ID      = 1,
  parameter int MEM_BYTES      = 65536,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic                cpu_req_write,
  input  logic [63:0]         cpu_req_address,
  input  logic [63:0]         cpu_req_wdata,
  output logic                cpu_rsp_valid,
  output logic [63:0]         cpu_rsp_rdata,
  output logic                cpu_rsp_error,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output bus_packet_type_t    bus_req_type,
  output logic [63:0]         bus_req_address,
  output bus_packet_payload_t bus_req_payload,
  output logic [7:0]          bus_req_source,
  input  logic                bus_rsp_valid,
  input  logic [63:0]         bus_rsp_payload,
  input  logic [7:0]          bus_rsp_dest
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65536");
  end

  localparam logic [63:0] MEM_SIZE = 64'(MEM_BYTES);

  initiator_state_t state;
  logic             rsp_match;
  logic             in_range;
  logic             timed_out;

  assign rsp_match      = bus_rsp_valid && (bus_rsp_dest == 8'(SOURCE_ID));
  assign in_range       = addr_in_range(cpu_req_address, MEM_SIZE);

  assign cpu_req_ready  = (state == IDLE);
  assign bus_req_valid  = (state == ISSUE);
  assign cpu_rsp_valid  = (state == DONE);
  assign bus_req_source = 8'(SOURCE_ID);

`ifdef MEM_BUS_TIMEOUT_EN
  logic [15:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == ISSUE) begin
      wd_cnt <= '0;
    end else if (state == WAIT_RSP) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign timed_out = (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus_req_type    <= bus_read_data;
      bus_req_address <= '0;
      bus_req_payload <= '0;
      cpu_rsp_error   <= 1'b0;
      cpu_rsp_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            bus_req_type    <= cpu_req_write ? bus_write_data : bus_read_data;
            bus_req_address <= cpu_req_address;
            bus_req_payload <= cpu_req_wdata;
            cpu_rsp_error   <= !in_range;
            state           <= in_range ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          if (bus_req_ready) begin
            state <= (bus_req_type == bus_write_data) ? DONE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A matching response wins over a watchdog expiry in the same cycle.
          if (rsp_match) begin
            cpu_rsp_rdata <= bus_rsp_payload;
            cpu_rsp_error <= 1'b0;
            state         <= DONE;
          end else if (timed_out) begin
            cpu_rsp_error <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
